// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Width of one carry-chained slice.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configuration: slices tile the word exactly and each is at least 1 bit.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result stream with valid/ready handshake on both sides.
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );
endinterface

// File: rtl/pipelined_adder_slice.sv
// Combinational CHUNK-bit ripple-carry chain; one per pipeline stage.
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    // Ripple the carry bit by bit; c_msb taps the carry entering the top bit.
    always_comb begin
        logic c;
        sum   = '0;
        c_msb = 1'b0;
        c     = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: STAGES carry-chained slices with operand skew,
// result deskew and a global-enable valid/ready pipeline.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [STAGES:1]  vld_pipe_q;
    logic             ovf_q;

    // Whole pipe moves together unless the output beat is stuck.
    assign en           = ~vld_pipe_q[STAGES] | bus.out_ready;
    assign bus.in_ready = en;

    // Subtract is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
    assign b_eff = bus.b ^ {WIDTH{bus.sub}};
    assign c_eff = bus.cin ^ bus.sub;

    // Valid shift register; bubbles enter whenever in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else if (en) begin
            vld_pipe_q[1] <= bus.in_valid;
            for (int k = 2; k <= STAGES; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int REM  = (STAGES - 1 - s) * CHUNK;   // operand bits still pending
        localparam int DONE = (s + 1) * CHUNK;            // result bits produced so far

        logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
        logic             sl_cin, sl_cout, sl_cmsb;
        logic [DONE-1:0]  res_d, res_q;
        logic             cy_q;

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (sl_a),
            .b    (sl_b),
            .cin  (sl_cin),
            .sum  (sl_sum),
            .cout (sl_cout),
            .c_msb(sl_cmsb)
        );

        if (s == 0) begin : g_src
            assign sl_a   = bus.a[CHUNK-1:0];
            assign sl_b   = b_eff[CHUNK-1:0];
            assign sl_cin = c_eff;
            assign res_d  = sl_sum;
        end else begin : g_src
            assign sl_a   = g_st[s-1].g_skew.opa_q[CHUNK-1:0];
            assign sl_b   = g_st[s-1].g_skew.opb_q[CHUNK-1:0];
            assign sl_cin = g_st[s-1].cy_q;
            assign res_d  = {sl_sum, g_st[s-1].res_q};
        end

        // Skew: upper operand chunks wait here until their slice's turn.
        if (s < STAGES - 1) begin : g_skew
            logic [REM-1:0] opa_d, opb_d, opa_q, opb_q;
            if (s == 0) begin : g_in
                assign opa_d = bus.a[WIDTH-1:CHUNK];
                assign opb_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_in
                assign opa_d = g_st[s-1].g_skew.opa_q[REM+CHUNK-1:CHUNK];
                assign opb_d = g_st[s-1].g_skew.opb_q[REM+CHUNK-1:CHUNK];
            end

            // Pending operand chunks advance with the beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (en) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                end
            end
        end

        // Deskew: finished low chunks ride along with the stage's new chunk and carry.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                res_q <= '0;
                cy_q  <= 1'b0;
            end else if (en) begin
                res_q <= res_d;
                cy_q  <= sl_cout;
            end
        end

        if (s == STAGES - 1) begin : g_ovf
            // Signed overflow: carry into MSB differs from carry out of MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     ovf_q <= 1'b0;
                else if (en) ovf_q <= sl_cmsb ^ sl_cout;
            end
        end
    end

    assign bus.out_valid = vld_pipe_q[STAGES];
    assign bus.sum       = g_st[STAGES-1].res_q;
    assign bus.carry     = g_st[STAGES-1].cy_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: a 16-bit/4-stage and an 8-bit/1-stage instance.
module tb_pipelined_adder;
    import adder_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        carry;
        logic        ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) bus16();
    pipelined_adder_if #(.WIDTH(8))  bus8();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pops16  = 0;
    int   pop_cyc16[$];
    exp_t q16[$];
    exp_t q8[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.sum = s; e.carry = c; e.ov = o;
        return e;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint m, ua, ub, ci, sa, sb, r, sr;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        ci = cin ? 1 : 0;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            r  = ua - ub - ci;
            sr = sa - sb - ci;
            e.carry = (r >= 0);
        end else begin
            r  = ua + ub + ci;
            sr = sa + sb + ci;
            e.carry = (r >= m);
        end
        r     = ((r % m) + m) % m;
        e.sum = 16'(r);
        e.ov  = (sr >= m / 2) || (sr < -(m / 2));
        return e;
    endfunction

    // Present one beat, hold it until accepted, push its expectation on accept.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input exp_t e);
        bus16.in_valid = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus16.in_ready) begin
                q16.push_back(e);
                @(posedge clk); #1;
                bus16.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send16_timeout", 32'd1, 32'd0);
        bus16.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input exp_t e);
        bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus8.in_ready) begin
                q8.push_back(e);
                @(posedge clk); #1;
                bus8.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send8_timeout", 32'd1, 32'd0);
        bus8.in_valid = 1'b0;
    endtask

    task automatic rand16();
        logic [15:0] a, b;
        logic cin, sub;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        send16(a, b, cin, sub, model(16, a, b, cin, sub));
    endtask

    task automatic drain(input int which);
        int t;
        for (t = 0; t < 60; t++) begin
            @(negedge clk);
            if ((which == 16 ? q16.size() : q8.size()) == 0) break;
        end
        if (t == 60) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    // Count edges from the accept edge until out_valid shows up.
    task automatic latency(input int which, input int exp_lat);
        int cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            cnt++;
            if ((which == 16) ? bus16.out_valid : bus8.out_valid) break;
        end
        chk(which == 16 ? "latency16" : "latency8", 32'(cnt), 32'(exp_lat));
    endtask

    // Monitor: pop and compare on every completed output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus16.out_valid && bus16.out_ready) begin
                if (q16.size() == 0) begin
                    chk("stray_out16", 32'd1, 32'd0);
                end else begin
                    e = q16.pop_front();
                    chk("sum16", 32'(bus16.sum), 32'(e.sum));
                    chk("carry16", 32'(bus16.carry), 32'(e.carry));
                    chk("ovf16", 32'(bus16.overflow), 32'(e.ov));
                    pops16++;
                    pop_cyc16.push_back(cyc);
                end
            end
            if (!rst && bus8.out_valid && bus8.out_ready) begin
                if (q8.size() == 0) begin
                    chk("stray_out8", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", 32'(bus8.sum), 32'(e.sum[7:0]));
                    chk("carry8", 32'(bus8.carry), 32'(e.carry));
                    chk("ovf8", 32'(bus8.overflow), 32'(e.ov));
                end
            end
        end
    end

    initial begin
        int base, cnt;
        logic [15:0] snap;
        bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0; bus16.sub = 0;
        bus16.out_ready = 1;
        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.sub = 0;
        bus8.out_ready = 1;
        rst = 1'b1;
        #2;
        chk("rst_out_valid16", 32'(bus16.out_valid), 0);
        chk("rst_sum16", 32'(bus16.sum), 0);
        chk("rst_carry16", 32'(bus16.carry), 0);
        chk("rst_ovf16", 32'(bus16.overflow), 0);
        chk("rst_in_ready16", 32'(bus16.in_ready), 1);
        chk("rst_out_valid8", 32'(bus8.out_valid), 0);
        chk("rst_in_ready8", 32'(bus8.in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed boundary beats, expectations written out by hand.
        send16(16'hFFFF, 16'h0001, 0, 0, mk(16'h0000, 1, 0));
        latency(16, 4);
        drain(16);
        send16(16'h7FFF, 16'h0001, 0, 0, mk(16'h8000, 0, 1));
        send16(16'h0005, 16'h0007, 0, 1, mk(16'hFFFE, 0, 0));
        send16(16'h0005, 16'h0007, 1, 1, mk(16'hFFFD, 0, 0));
        send16(16'h1234, 16'h1234, 0, 1, mk(16'h0000, 1, 0));
        send16(16'h8000, 16'h0001, 0, 1, mk(16'h7FFF, 1, 1));
        drain(16);

        // Streaming: 20 back-to-back beats must come out on 20 consecutive cycles.
        base = pops16;
        for (int i = 0; i < 20; i++) rand16();
        drain(16);
        chk("stream_count", 32'(pops16 - base), 20);
        if (pops16 - base == 20)
            chk("stream_span", 32'(pop_cyc16[base + 19] - pop_cyc16[base]), 19);

        // Back-pressure: 3 stalled cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 12; i++) rand16();
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus16.out_ready = 1'b0;
                @(negedge clk);
                chk("bp_out_valid", 32'(bus16.out_valid), 1);
                chk("bp_in_ready0", 32'(bus16.in_ready), 0);
                snap = bus16.sum;
                for (int k = 1; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus16.in_ready), 0);
                    chk("bp_sum_hold", 32'(bus16.sum), 32'(snap));
                end
                @(posedge clk); #1 bus16.out_ready = 1'b1;
            end
        join
        drain(16);

        // out_ready toggling with an empty pipe has no effect.
        for (int i = 0; i < 4; i++) begin
            bus16.out_ready = 1'(i);
            @(negedge clk);
            chk("idle_in_ready", 32'(bus16.in_ready), 1);
            chk("idle_out_valid", 32'(bus16.out_valid), 0);
            @(posedge clk); #1;
        end
        bus16.out_ready = 1'b1;

        // Reset with beats in flight: everything is discarded.
        for (int i = 0; i < 6; i++) rand16();
        chk("pre_rst_valid", 32'(bus16.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus16.out_valid), 0);
        chk("midrst_in_ready", 32'(bus16.in_ready), 1);
        q16.delete();
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus16.out_valid) cnt++;
        end
        chk("no_stale_beats", 32'(cnt), 0);
        @(posedge clk); #1;

        // Single-stage 8-bit instance.
        send8(8'h80, 8'h80, 0, 0, mk(16'h0000, 1, 1));
        latency(8, 1);
        drain(8);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] a, b;
            logic ci, sb;
            a = 8'($urandom); b = 8'($urandom);
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            send8(a, b, ci, sb, model(8, {8'h00, a}, {8'h00, b}, ci, sb));
        end
        drain(8);

        chk("q16_empty", 32'(q16.size()), 0);
        chk("q8_empty", 32'(q8.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
